// File: rtl/uart_fifo_pkg.sv
// Shared constants and types for the parametrised UART FIFO.
package uart_fifo_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 16;

   // Pointer width: address bits plus one wrap bit.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef logic [ptr_w(DEPTH_DEF)-1:0] level_t;

endpackage

// File: rtl/uart_fifo_if.sv
// FIFO request/response bundle; master is the register-file/shifter side, slave is the FIFO.
interface uart_fifo_if
   import uart_fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
);
   localparam int LW = ptr_w(DEPTH);

   logic              flush;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              full;
   logic              empty;
   logic [LW-1:0]     level;
   logic [LW-1:0]     trig_lvl;
   logic              trig;
   logic              err_clr;
   logic              ovf;
   logic              udf;

   modport master (
      output flush, wr_en, wr_data, rd_en, trig_lvl, err_clr,
      input  rd_data, rd_valid, full, empty, level, trig, ovf, udf
   );

   modport slave (
      input  flush, wr_en, wr_data, rd_en, trig_lvl, err_clr,
      output rd_data, rd_valid, full, empty, level, trig, ovf, udf
   );

endinterface

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port; swappable for a technology RAM.
module uart_fifo_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we_i,
   input  logic [$clog2(DEPTH)-1:0]   waddr_i,
   input  logic [DATA_W-1:0]          wdata_i,
   input  logic                       re_i,
   input  logic [$clog2(DEPTH)-1:0]   raddr_i,
   output logic [DATA_W-1:0]          rdata_o
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // NOTE: the storage array has no reset so it can map onto RAM macros; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      if (rst)       rdata_q <= '0;
      else if (re_i) rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_fifo_gen.sv
// Parametrised synchronous UART FIFO: pointers, flags, trigger and optional sticky errors.
// Define UART_FIFO_ERR_EN to build the ovf/udf sticky error flags.
module uart_fifo_gen
   import uart_fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic            clk,
   input  logic            rst,
   uart_fifo_if.slave      bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = ptr_w(DEPTH);

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic          rd_valid_q, rd_valid_d;
   logic [PW-1:0] level;
   logic [PW-1:0] trig_thr;
   logic          full, empty;
   logic          wr_acc, rd_acc;
   logic          ram_we, ram_re;

   // Flags come straight from the registered pointers, so they carry no extra lag.
   assign level    = wptr_q - rptr_q;
   assign empty    = (wptr_q == rptr_q);
   assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign trig_thr = (bus.trig_lvl == '0) ? PW'(1) : bus.trig_lvl;

   assign wr_acc = bus.wr_en && !full;
   assign rd_acc = bus.rd_en && !empty;
   assign ram_we = wr_acc && !bus.flush;
   assign ram_re = rd_acc && !bus.flush;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      rd_valid_d = 1'b0;
      if (bus.flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (wr_acc) wptr_d = wptr_q + PW'(1);
         if (rd_acc) rptr_d = rptr_q + PW'(1);
         rd_valid_d = rd_acc;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   uart_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (ram_we),
      .waddr_i (wptr_q[AW-1:0]),
      .wdata_i (bus.wr_data),
      .re_i    (ram_re),
      .raddr_i (rptr_q[AW-1:0]),
      .rdata_o (bus.rd_data)
   );

   assign bus.rd_valid = rd_valid_q;
   assign bus.full     = full;
   assign bus.empty    = empty;
   assign bus.level    = level;
   assign bus.trig     = (level >= trig_thr);

`ifdef UART_FIFO_ERR_EN
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   // A new error event in the same cycle as err_clr wins.
   always_comb begin
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (bus.err_clr) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
      if (bus.wr_en && full)  ovf_d = 1'b1;
      if (bus.rd_en && empty) udf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign bus.ovf = ovf_q;
   assign bus.udf = udf_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = bus.err_clr;
   assign bus.ovf        = 1'b0;
   assign bus.udf        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_gen.sv
// Self-checking bench for uart_fifo_gen: directed test-plan sequences plus randomized traffic vs a queue model.
module tb_uart_fifo_gen;
   import uart_fifo_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
`ifdef UART_FIFO_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

   uart_fifo_gen #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: a queue of stored words plus the visible read register and sticky flags.
   logic [DW-1:0] mq [$];
   logic [DW-1:0] m_rd_data = '0;
   bit            m_rv  = 1'b0;
   bit            m_ovf = 1'b0;
   bit            m_udf = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit w, input logic [DW-1:0] d, input bit r);
      rst         = 1'b0;
      bus.flush   = 1'b0;
      bus.err_clr = 1'b0;
      bus.wr_en   = w;
      bus.wr_data = d;
      bus.rd_en   = r;
   endtask

   // One clock: update the model from the inputs seen at the edge, then compare every output.
   task automatic tick();
      int sz;
      int thr;
      @(posedge clk);
      sz = mq.size();
      if (rst) begin
         mq.delete();
         m_rd_data = '0;
         m_rv      = 1'b0;
         m_ovf     = 1'b0;
         m_udf     = 1'b0;
      end else begin
         if (ERR_EN) begin
            if (bus.wr_en && sz == DEPTH) m_ovf = 1'b1;
            else if (bus.err_clr)         m_ovf = 1'b0;
            if (bus.rd_en && sz == 0)     m_udf = 1'b1;
            else if (bus.err_clr)         m_udf = 1'b0;
         end
         if (bus.flush) begin
            mq.delete();
            m_rv = 1'b0;
         end else begin
            m_rv = 1'b0;
            if (bus.rd_en && sz > 0) begin
               m_rd_data = mq.pop_front();
               m_rv      = 1'b1;
            end
            if (bus.wr_en && sz < DEPTH) mq.push_back(bus.wr_data);
         end
      end
      #1;
      thr = (bus.trig_lvl == 0) ? 1 : int'(bus.trig_lvl);
      check("level",    32'(bus.level),    32'(mq.size()));
      check("empty",    32'(bus.empty),    32'(mq.size() == 0));
      check("full",     32'(bus.full),     32'(mq.size() == DEPTH));
      check("trig",     32'(bus.trig),     32'(mq.size() >= thr));
      check("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
      check("rd_data",  32'(bus.rd_data),  32'(m_rd_data));
      check("ovf",      32'(bus.ovf),      32'(m_ovf));
      check("udf",      32'(bus.udf),      32'(m_udf));
   endtask

   task automatic write_n(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, DW'($urandom), 1'b0);
         tick();
      end
   endtask

   task automatic read_n(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, '0, 1'b1);
         tick();
      end
   endtask

   initial begin
      drive(1'b0, '0, 1'b0);
      bus.trig_lvl = 5'd8;
      rst = 1'b1;
      tick();
      check("reset_empty", 32'(bus.empty), 32'd1);

      // Fill 0x00..0x0F, then one write too many.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, DW'(i), 1'b0);
         tick();
      end
      check("fill_full",  32'(bus.full),  32'd1);
      check("fill_level", 32'(bus.level), 32'd16);
      drive(1'b1, 8'hAA, 1'b0);
      tick();
      check("ovf_after_17th", 32'(bus.ovf), 32'(ERR_EN));

      // Drain in order, then one read too many.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, '0, 1'b1);
         tick();
         check("drain_data",  32'(bus.rd_data),  32'(i));
         check("drain_valid", 32'(bus.rd_valid), 32'd1);
      end
      check("drain_empty", 32'(bus.empty), 32'd1);
      drive(1'b0, '0, 1'b1);
      tick();
      check("extra_rd_hold", 32'(bus.rd_data), 32'h0F);
      check("extra_rd_udf",  32'(bus.udf),     32'(ERR_EN));
      drive(1'b0, '0, 1'b0);
      tick();
      check("rd_valid_drop", 32'(bus.rd_valid), 32'd0);

      drive(1'b0, '0, 1'b0);
      bus.err_clr = 1'b1;
      tick();

      // Wrap across the pointer MSB.
      for (int k = 0; k < 3; k++) begin
         write_n(10);
         read_n(10);
      end

      // Simultaneous read and write at level 5, full and empty.
      write_n(5);
      drive(1'b1, 8'h55, 1'b1);
      tick();
      check("simul_lvl5", 32'(bus.level), 32'd5);
      write_n(11);
      drive(1'b1, 8'h66, 1'b1);
      tick();
      check("simul_full", 32'(bus.level), 32'd15);
      read_n(15);
      drive(1'b1, 8'h77, 1'b1);
      tick();
      check("simul_empty", 32'(bus.level), 32'd1);
      read_n(1);

      // Trigger threshold 8 up and down, then threshold 0 acting as 1.
      bus.trig_lvl = 5'd8;
      write_n(7);
      check("trig_lvl7_lo", 32'(bus.trig), 32'd0);
      write_n(1);
      check("trig_lvl8_hi", 32'(bus.trig), 32'd1);
      read_n(1);
      check("trig_fall_7", 32'(bus.trig), 32'd0);
      read_n(7);
      bus.trig_lvl = 5'd0;
      #1;
      check("trig0_empty", 32'(bus.trig), 32'd0);
      write_n(1);
      check("trig0_one", 32'(bus.trig), 32'd1);
      read_n(1);
      bus.trig_lvl = 5'd8;

      // Flush with both requests at level 9, sticky state preserved.
      read_n(1);
      write_n(9);
      drive(1'b1, 8'h99, 1'b1);
      bus.flush = 1'b1;
      tick();
      check("flush_level", 32'(bus.level),    32'd0);
      check("flush_valid", 32'(bus.rd_valid), 32'd0);
      check("flush_udf",   32'(bus.udf),      32'(ERR_EN));

      // Reset in the middle of traffic.
      write_n(6);
      drive(1'b1, 8'h11, 1'b1);
      rst = 1'b1;
      tick();
      check("rst_level", 32'(bus.level), 32'd0);

      // Randomized traffic with alternating write-heavy / read-heavy phases.
      for (int i = 0; i < 3000; i++) begin
         bit heavy_wr;
         heavy_wr = ((i / 250) % 2) == 0;
         drive($urandom_range(0, 99) < (heavy_wr ? 70 : 30), DW'($urandom),
               $urandom_range(0, 99) < (heavy_wr ? 30 : 70));
         bus.err_clr = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 99) == 0) bus.trig_lvl = 5'($urandom_range(0, DEPTH));
         if ($urandom_range(0, 199) == 0) begin
            bus.flush = 1'b1;
            bus.wr_en = 1'b0;
            bus.rd_en = 1'b0;
         end
         if ($urandom_range(0, 799) == 0) rst = 1'b1;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_fifo_gen.md
# uart_fifo_gen

Parametrised synchronous FIFO for the APB UART TX and RX data paths. It generalises the fixed 8×16 UART FIFO to configurable data width and depth. It adds a programmable trigger level, a registered read-data valid strobe, a combinational occupancy count with no lag, and optional sticky overflow/underflow error flags. One instance sits between the APB register file and the TX shifter, and another sits between the RX shifter and the register file.

## Interface
Parameters:
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AW, $clog2(DEPTH), address width; derived, not overridden

Ports:
- clk  input  1  functional clock; all logic on the rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  soft clear of the FIFO contents (e.g. FCR RX/TX reset bit)
- wr_en  input  1  write request
- wr_data  input  DATA_W  write data
- rd_en  input  1  read request
- rd_data  output  DATA_W  registered read data
- rd_valid  output  1  one-cycle strobe: rd_data was updated this cycle
- full  output  1  level == DEPTH
- empty  output  1  level == 0
- level  output  AW+1  current occupancy, 0..DEPTH
- trig_lvl  input  AW+1  trigger threshold, 1..DEPTH
- trig  output  1  level ≥ trig_lvl (trig_lvl = 0 is treated as 1)
- err_clr  input  1  clears the sticky error flags (UART_FIFO_ERR_EN only)
- ovf  output  1  sticky: write attempted while full (UART_FIFO_ERR_EN only)
- udf  output  1  sticky: read attempted while empty (UART_FIFO_ERR_EN only)

## Operation
- Pointers wptr and rptr are AW+1 bits wide. The extra MSB is a wrap bit.
  - level = wptr − rptr, modulo 2^(AW+1).
  - empty = (wptr == rptr).
  - full = (MSBs differ and low AW bits equal).
- Write accept: wr_en && !full. On accept, mem[wptr[AW-1:0]] ← wr_data and wptr increments.
- Read accept: rd_en && !empty. On accept, rd_data ← mem[rptr[AW-1:0]], rd_valid = 1 for the next cycle, and rptr increments.
- Both accept conditions use the flags at the start of the cycle:
  - When full, a write is rejected even if a read is accepted in the same cycle.
  - When empty, a read is rejected even if a write is accepted in the same cycle.
- Simultaneous accepted read and write: level is unchanged, and both pointers advance.
- Pointers wrap naturally at 2^(AW+1). No special case is needed.
- flush has priority over rd_en and wr_en:
  - Both pointers go to 0 and rd_valid goes to 0.
  - rd_data holds its value.
  - Memory contents are not cleared.
  - Sticky error flags are unaffected.
- rst: pointers = 0, rd_data = 0, rd_valid = 0, ovf = udf = 0. Memory is not reset.
  - The resulting outputs are empty = 1, full = 0, level = 0, and trig = 0.
  - rst asserted during traffic discards all entries on the next edge.
- A rejected request has no effect on the data path.

## Timing
- Write-to-empty deassert: wr_en at edge N means empty = 0 and level = 1 after edge N.
- Read latency: rd_en accepted at edge N means rd_data and rd_valid are valid after edge N. rd_valid drops after edge N+1 unless another read is accepted.
- level, full, empty and trig are combinational from the pointers and trig_lvl. They reflect state at the current edge with no extra cycle of lag.
- Back-to-back reads and writes are sustained at one per cycle.

## Configuration
- Macro: UART_FIFO_ERR_EN.
- When defined:
  - ovf sets on wr_en && full.
  - udf sets on rd_en && empty.
  - Both hold until err_clr or rst. If err_clr and a new error event fall in the same cycle, set wins.
- When undefined:
  - ovf and udf are tied to 0.
  - err_clr is ignored.
  - No error flops are generated.

## Structure
- Package uart_fifo_pkg:
  - Default DATA_W and DEPTH constants.
  - Pointer-width helper function.
  - Typedef for the level type.
- Sub-module uart_fifo_ram: simple dual-port, one write port and one registered read port, DATA_W × DEPTH. This allows it to be swapped for a technology RAM.
- Pointer, flag, trigger and error logic live in uart_fifo_gen.

## Test plan
- Reset then fill (DATA_W = 8, DEPTH = 16): write 0x00..0x0F → full = 1 and level = 16 after the 16th write. A 17th write with ovf enabled → data unchanged and ovf = 1.
- Drain: 16 reads → rd_data = 0x00..0x0F in order, each with rd_valid one cycle after rd_en, and empty = 1 after the last read. An extra read → udf = 1, with rd_valid = 0 and rd_data held.
- Wrap: repeat write 10 / read 10 three times → data order preserved and level correct across a pointer MSB wrap.
- Simultaneous read and write:
  - At level 5 → level stays 5.
  - When full → the write is rejected and level = 15.
  - When empty → the read is rejected and level = 1.
- Trigger: trig_lvl = 8 → trig rises in the same cycle that level reaches 8, and falls when level reaches 7. trig_lvl = 0 behaves as 1.
- Flush and reset mid-stream:
  - flush with wr_en and rd_en asserted at level 9 → level = 0, rd_valid = 0, ovf/udf unchanged.
  - rst → all outputs at their reset values on the next edge.
